// File: rtl/fios_operand_server.sv
// Operand/result endpoint for one FIOS Montgomery multiplier: loads a/b/p, serves windows and words, collects results.
// Latency: operand outputs are combinational from registered pointers; one START cycle precedes RUN.
// Backpressure: load_ready_o only in LOAD; results drain on res_valid_o/res_ready_i. Optional FIOS_OPSRV_CYCLE_COUNT_EN adds cycles_o.
module fios_operand_server #(
  parameter int s     = 8,
  parameter int PE_NB = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  load_valid_i,
  input  logic [1:0]            load_sel_i,
  input  logic [16:0]           load_data_i,
  output logic                  load_ready_o,
  input  logic                  go_i,
  output logic                  busy_o,
  output logic                  start_o,
  output logic [PE_NB*17-1:0]   a_o,
  output logic [16:0]           b_o,
  output logic [16:0]           p_o,
  input  logic                  a_shift_i,
  input  logic                  b_fetch_i,
  input  logic                  p_fetch_i,
  input  logic                  res_push_i,
  input  logic [16:0]           res_i,
  input  logic                  done_i,
  output logic                  res_valid_o,
  output logic [16:0]           res_data_o,
  input  logic                  res_ready_i,
`ifdef FIOS_OPSRV_CYCLE_COUNT_EN
  output logic [31:0]           cycles_o,
`endif
  output logic                  err_o
);

  localparam int PW = $clog2(s);
  localparam int CW = $clog2(s + 1);
  localparam int AW = $clog2(2 * s) + 1;
  localparam logic [CW-1:0] S_CNT  = CW'(s);
  localparam logic [PW-1:0] S_LAST = PW'(s - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_START, ST_RUN, ST_DRAIN} state_t;
  state_t state_q, state_d;

  logic [16:0] a_mem   [s];
  logic [16:0] b_mem   [s];
  logic [16:0] p_mem   [s];
  logic [16:0] res_mem [s];

  logic [2:0][CW-1:0] cnt_q;
  logic [PW-1:0]      a_base_q, b_ptr_q, p_ptr_q, rd_q;
  logic [CW-1:0]      res_wr_q;
  logic               err_q;

  logic               load_we, push_we, beat, err_set, strobe_any;
  logic [AW-1:0]      a_sum;

  assign strobe_any = a_shift_i | b_fetch_i | p_fetch_i | res_push_i;
  assign a_sum      = AW'(a_base_q) + AW'(PE_NB);

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) state_q <= ST_LOAD;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    load_ready_o = 1'b0;
    start_o      = 1'b0;
    res_valid_o  = 1'b0;
    load_we      = 1'b0;
    push_we      = 1'b0;
    beat         = 1'b0;
    err_set      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_ready_o = 1'b1;
        if (load_valid_i && load_sel_i != 2'd3) begin
          if (cnt_q[load_sel_i] != S_CNT) load_we = 1'b1;
          else                            err_set = 1'b1;
        end
        if (go_i) begin
          if (cnt_q[0] == S_CNT && cnt_q[1] == S_CNT && cnt_q[2] == S_CNT) state_d = ST_START;
          else                                                             err_set = 1'b1;
        end
        if (strobe_any || done_i) err_set = 1'b1;
      end
      ST_START: begin
        start_o = 1'b1;
        state_d = ST_RUN;
        if (strobe_any || done_i) err_set = 1'b1;
      end
      ST_RUN: begin
        if (res_push_i) begin
          if (res_wr_q != S_CNT) push_we = 1'b1;
          else                   err_set = 1'b1;
        end
        // a push in the same cycle as done counts toward completeness
        if (done_i) begin
          state_d = ST_DRAIN;
          if (res_wr_q + CW'(push_we) != S_CNT) err_set = 1'b1;
        end
      end
      ST_DRAIN: begin
        res_valid_o = 1'b1;
        if (strobe_any) err_set = 1'b1;
        if (res_ready_i) begin
          beat = 1'b1;
          if (rd_q == S_LAST) state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      cnt_q    <= '0;
      a_base_q <= '0;
      b_ptr_q  <= '0;
      p_ptr_q  <= '0;
      rd_q     <= '0;
      res_wr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      if (load_we) cnt_q[load_sel_i] <= cnt_q[load_sel_i] + CW'(1);
      case (state_q)
        ST_START: begin
          a_base_q <= '0;
          b_ptr_q  <= '0;
          p_ptr_q  <= '0;
          res_wr_q <= '0;
        end
        ST_RUN: begin
          if (a_shift_i) a_base_q <= (a_sum >= AW'(s)) ? '0 : a_sum[PW-1:0];
          if (b_fetch_i) b_ptr_q  <= (b_ptr_q == S_LAST) ? '0 : b_ptr_q + PW'(1);
          if (p_fetch_i) p_ptr_q  <= (p_ptr_q == S_LAST) ? '0 : p_ptr_q + PW'(1);
          if (push_we)   res_wr_q <= res_wr_q + CW'(1);
          if (done_i)    rd_q     <= '0;
        end
        ST_DRAIN: begin
          if (beat) begin
            rd_q <= (rd_q == S_LAST) ? '0 : rd_q + PW'(1);
            if (rd_q == S_LAST) cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // storage is deliberately left uninitialised across reset
  always_ff @(posedge clock_i) begin
    if (load_we) begin
      case (load_sel_i)
        2'd0:    a_mem[cnt_q[0][PW-1:0]] <= load_data_i;
        2'd1:    b_mem[cnt_q[1][PW-1:0]] <= load_data_i;
        2'd2:    p_mem[cnt_q[2][PW-1:0]] <= load_data_i;
        default: ;
      endcase
    end
    if (push_we) res_mem[res_wr_q[PW-1:0]] <= res_i;
  end

  for (genvar k = 0; k < PE_NB; k++) begin : g_win
    logic [AW-1:0] idx;
    assign idx             = AW'(a_base_q) + AW'(k);
    assign a_o[17*k +: 17] = (idx < AW'(s)) ? a_mem[idx[PW-1:0]] : 17'd0;
  end

  assign b_o        = b_mem[b_ptr_q];
  assign p_o        = p_mem[p_ptr_q];
  assign res_data_o = res_mem[rd_q];
  assign busy_o     = (state_q != ST_LOAD);
  assign err_o      = err_q;

`ifdef FIOS_OPSRV_CYCLE_COUNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clock_i) begin
    if (!reset_n_i)                                  cyc_q <= '0;
    else if (state_q == ST_START)                    cyc_q <= '0;
    else if (state_q == ST_RUN && cyc_q != '1)       cyc_q <= cyc_q + 32'd1;
  end
  assign cycles_o = cyc_q;
`endif

endmodule

// File: tb/tb_fios_operand_server.sv
// Bench for fios_operand_server: two instances (PE_NB=8 and PE_NB=3) share stimulus and are checked against a queue/array model.
module tb_fios_operand_server;
  localparam int S = 8;

  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic reset_n_i, load_valid_i, go_i, a_shift_i, b_fetch_i, p_fetch_i, res_push_i, done_i, res_ready_i;
  logic [1:0]  load_sel_i;
  logic [16:0] load_data_i, res_i;

  logic        load_ready_8, busy_8, start_8, res_valid_8, err_8;
  logic        load_ready_3, busy_3, start_3, res_valid_3, err_3;
  logic [16:0] b_8, p_8, res_data_8, b_3, p_3, res_data_3;
  logic [8*17-1:0] a_8;
  logic [3*17-1:0] a_3;
`ifdef FIOS_OPSRV_CYCLE_COUNT_EN
  logic [31:0] cycles_8, cycles_3;
`endif

  fios_operand_server #(.s(S), .PE_NB(8)) u_dut8 (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .load_valid_i(load_valid_i), .load_sel_i(load_sel_i),
    .load_data_i(load_data_i), .load_ready_o(load_ready_8), .go_i(go_i), .busy_o(busy_8),
    .start_o(start_8), .a_o(a_8), .b_o(b_8), .p_o(p_8), .a_shift_i(a_shift_i), .b_fetch_i(b_fetch_i),
    .p_fetch_i(p_fetch_i), .res_push_i(res_push_i), .res_i(res_i), .done_i(done_i),
    .res_valid_o(res_valid_8), .res_data_o(res_data_8), .res_ready_i(res_ready_i),
`ifdef FIOS_OPSRV_CYCLE_COUNT_EN
    .cycles_o(cycles_8),
`endif
    .err_o(err_8));

  fios_operand_server #(.s(S), .PE_NB(3)) u_dut3 (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .load_valid_i(load_valid_i), .load_sel_i(load_sel_i),
    .load_data_i(load_data_i), .load_ready_o(load_ready_3), .go_i(go_i), .busy_o(busy_3),
    .start_o(start_3), .a_o(a_3), .b_o(b_3), .p_o(p_3), .a_shift_i(a_shift_i), .b_fetch_i(b_fetch_i),
    .p_fetch_i(p_fetch_i), .res_push_i(res_push_i), .res_i(res_i), .done_i(done_i),
    .res_valid_o(res_valid_3), .res_data_o(res_data_3), .res_ready_i(res_ready_i),
`ifdef FIOS_OPSRV_CYCLE_COUNT_EN
    .cycles_o(cycles_3),
`endif
    .err_o(err_3));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: operand images, result image, counts of strobes since start
  logic [16:0] ma [S];
  logic [16:0] mb [S];
  logic [16:0] mp [S];
  logic [16:0] mres [S];
  int nshift, nfb, nfp, mwr;
  logic merr;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // {load_ready, busy, start, res_valid, err}
  task automatic chk_ctrl(input string tag, input logic rdy, input logic bsy, input logic st, input logic vld);
    chk({tag, "_ctl8"}, {load_ready_8, busy_8, start_8, res_valid_8, err_8}, {rdy, bsy, st, vld, merr});
    chk({tag, "_ctl3"}, {load_ready_3, busy_3, start_3, res_valid_3, err_3}, {rdy, bsy, st, vld, merr});
  endtask

  // window n of a PE_NB-wide scan: windows tile the operand, the last one zero-padded, then restart
  function automatic logic [255:0] win(input int n, input int pe);
    logic [255:0] v;
    int base;
    v = '0;
    base = (n % ((S + pe - 1) / pe)) * pe;
    for (int k = 0; k < pe; k++)
      if (base + k < S) v[17*k +: 17] = ma[base + k];
    return v;
  endfunction

  task automatic chk_operands(input string tag);
    chk({tag, "_a8"}, a_8, win(nshift, 8));
    chk({tag, "_a3"}, a_3, win(nshift, 3));
    chk({tag, "_b8"}, b_8, mb[nfb % S]);
    chk({tag, "_b3"}, b_3, mb[nfb % S]);
    chk({tag, "_p8"}, p_8, mp[nfp % S]);
    chk({tag, "_p3"}, p_3, mp[nfp % S]);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    merr = 1'b0;
  endtask

  task automatic load_word(input logic [1:0] sel, input logic [16:0] d);
    load_valid_i = 1'b1;
    load_sel_i   = sel;
    load_data_i  = d;
    tick();
    load_valid_i = 1'b0;
  endtask

  task automatic load_ops(input int np);
    for (int i = 0; i < S; i++) load_word(2'd0, ma[i]);
    for (int i = 0; i < S; i++) load_word(2'd1, mb[i]);
    for (int i = 0; i < np; i++) load_word(2'd2, mp[i]);
  endtask

  task automatic start_run(input string tag);
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
    chk_ctrl({tag, "_start"}, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_ctrl({tag, "_run"}, 1'b0, 1'b1, 1'b0, 1'b0);
    nshift = 0; nfb = 0; nfp = 0; mwr = 0;
  endtask

  task automatic push(input logic [16:0] v);
    res_push_i = 1'b1;
    res_i      = v;
    tick();
    res_push_i = 1'b0;
    if (mwr < S) begin
      mres[mwr] = v;
      mwr++;
    end else begin
      merr = 1'b1;
    end
  endtask

  task automatic drain(input bit rnd, input string tag);
    int got;
    got = 0;
    for (int c = 0; c < 100 && got < S; c++) begin
      res_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'(c % 2);
      if (res_valid_8 && res_ready_i) begin
        chk($sformatf("%s_beat%0d_8", tag, got), res_data_8, mres[got]);
        chk($sformatf("%s_beat%0d_3", tag, got), res_data_3, mres[got]);
        got++;
      end
      tick();
    end
    res_ready_i = 1'b0;
    chk({tag, "_beats"}, 32'(got), 32'(S));
    chk_ctrl({tag, "_end"}, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0; load_valid_i = 1'b0; load_sel_i = 2'd0; load_data_i = '0;
    go_i = 1'b0; a_shift_i = 1'b0; b_fetch_i = 1'b0; p_fetch_i = 1'b0;
    res_push_i = 1'b0; res_i = '0; done_i = 1'b0; res_ready_i = 1'b0;
    merr = 1'b0; nshift = 0; nfb = 0; nfp = 0; mwr = 0;
    tick(); tick();
    reset_n_i = 1'b1;
    chk_ctrl("reset", 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < S; i++) begin
      ma[i] = 17'(i + 1);
      mb[i] = 17'(16 + i);
      mp[i] = 17'h1FFFF;
    end

    // go with p one word short is refused
    load_ops(S - 1);
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
    merr = 1'b1;
    chk_ctrl("go_short", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctrl("go_short_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk_ctrl("reset2", 1'b1, 1'b0, 1'b0, 1'b0);

    // basic run
    load_ops(S);
    load_word(2'd3, 17'h1ABCD);
    chk_ctrl("loaded", 1'b1, 1'b0, 1'b0, 1'b0);
    start_run("basic");
    chk_operands("basic0");
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
    chk_ctrl("go_in_run", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      a_shift_i = 1'b1; tick(); a_shift_i = 1'b0; nshift++;
      chk_operands($sformatf("shift%0d", n));
    end
    for (int n = 1; n <= 9; n++) begin
      b_fetch_i = 1'b1; tick(); b_fetch_i = 1'b0; nfb++;
      chk_operands($sformatf("bfetch%0d", n));
    end
    chk("b_after_wrap", b_8, 17'h11);
    for (int n = 1; n <= 2; n++) begin
      p_fetch_i = 1'b1; tick(); p_fetch_i = 1'b0; nfp++;
      chk_operands($sformatf("pfetch%0d", n));
    end
    for (int i = 0; i < S; i++) push(17'(32'h100 + i));
    done_i = 1'b1; tick(); done_i = 1'b0;
    chk_ctrl("done", 1'b0, 1'b1, 1'b0, 1'b1);
    done_i = 1'b1; tick(); done_i = 1'b0;
    chk_ctrl("done_in_drain", 1'b0, 1'b1, 1'b0, 1'b1);
    drain(1'b0, "drain_toggle");

    // ninth push is dropped
    load_ops(S);
    start_run("over");
    for (int i = 0; i < S + 1; i++) begin
      push(17'(32'h200 + i));
      chk_ctrl($sformatf("over_push%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    done_i = 1'b1; tick(); done_i = 1'b0;
    drain(1'b0, "drain_over");
    do_reset();

    // strobe while idle
    a_shift_i = 1'b1; tick(); a_shift_i = 1'b0;
    merr = 1'b1;
    chk_ctrl("shift_in_load", 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();

    // done after only seven pushes
    load_ops(S);
    start_run("short");
    for (int i = 0; i < S - 1; i++) push(17'(32'h300 + i));
    done_i = 1'b1; tick(); done_i = 1'b0;
    merr = 1'b1;
    chk_ctrl("short_done", 1'b0, 1'b1, 1'b0, 1'b1);
    drain(1'b0, "drain_short");
    do_reset();

    // reset in the middle of a run
    load_ops(S);
    start_run("mid");
    for (int i = 0; i < 3; i++) push(17'(32'h400 + i));
    do_reset();
    chk_ctrl("rst_mid_run", 1'b1, 1'b0, 1'b0, 1'b0);
    load_ops(S);
    start_run("after_rst");
    chk_operands("after_rst");
    for (int i = 0; i < S; i++) push(17'(32'h500 + i));
    done_i = 1'b1; tick(); done_i = 1'b0;
    drain(1'b0, "drain_after_rst");

    // randomized runs
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < S; i++) begin
        ma[i] = 17'($urandom);
        mb[i] = 17'($urandom);
        mp[i] = 17'($urandom);
      end
      load_ops(S);
      start_run($sformatf("rnd%0d", it));
      for (int c = 0; c < 24; c++) begin
        a_shift_i = 1'($urandom_range(0, 1));
        b_fetch_i = 1'($urandom_range(0, 1));
        p_fetch_i = 1'($urandom_range(0, 1));
        tick();
        if (a_shift_i) nshift++;
        if (b_fetch_i) nfb++;
        if (p_fetch_i) nfp++;
        a_shift_i = 1'b0; b_fetch_i = 1'b0; p_fetch_i = 1'b0;
        chk_operands($sformatf("rnd%0d_c%0d", it, c));
      end
      for (int i = 0; i < S - 1; i++) push(17'($urandom));
      // last push lands together with done
      done_i = 1'b1;
      push(17'($urandom));
      done_i = 1'b0;
      chk_ctrl($sformatf("rnd%0d_done", it), 1'b0, 1'b1, 1'b0, 1'b1);
      drain(1'b1, $sformatf("rnd%0d_drain", it));
    end

`ifdef FIOS_OPSRV_CYCLE_COUNT_EN
    load_ops(S);
    start_run("cyc");
    for (int i = 0; i < S; i++) push(17'(32'h600 + i));
    repeat (41) tick();
    done_i = 1'b1; tick(); done_i = 1'b0;
    chk("cycles_drain_8", cycles_8, 32'd50);
    chk("cycles_drain_3", cycles_3, 32'd50);
    drain(1'b0, "drain_cyc");
    chk("cycles_load_8", cycles_8, 32'd50);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fios_operand_server.md
Name: fios_operand_server

Overview:
- Operand/result endpoint for the FIOS Montgomery multiplier top. It answers the multiplier's a_shift, b_fetch, p_fetch, RES_push and done strobes.
- Host side: loads a, b and p as 17-bit words, issues a one-cycle start, and buffers the s result words.
- Result words drain to the host over a valid/ready stream.
- Sits between the host/DMA interface and the multiplier top, one instance per multiplier.

Parameters:
- s, 8, operand length in 17-bit words (2..64)
- PE_NB, 8, PE count; width of the parallel a window (1..s)

Ports:
- clock_i  in  1  clock
- reset_n_i  in  1  synchronous reset, active low
- load_valid_i  in  1  host operand word valid
- load_sel_i  in  2  target operand: 0=a, 1=b, 2=p, 3=ignored (word accepted and dropped)
- load_data_i  in  17  operand word, least significant word first
- load_ready_o  out  1  high in LOAD only
- go_i  in  1  host request to start a multiplication
- busy_o  out  1  high outside LOAD
- start_o  out  1  one-cycle start pulse to the multiplier
- a_o  out  PE_NB*17  current a window; word k in bits [17k+16:17k]
- b_o  out  17  current b word
- p_o  out  17  current p word
- a_shift_i  in  1  advance a window
- b_fetch_i  in  1  advance b pointer
- p_fetch_i  in  1  advance p pointer
- res_push_i  in  1  result word strobe
- res_i  in  17  result word
- done_i  in  1  multiplication complete
- res_valid_o  out  1  result stream valid
- res_data_o  out  17  result stream data
- res_ready_i  in  1  result stream ready
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (reset_n_i low at a clock edge):
  - State=LOAD; all pointers and counters=0; err_o=0.
  - start_o, res_valid_o, busy_o = 0; load_ready_o = 1.
  - Operand and result RAM contents are not cleared.
- Storage: three s×17 operand arrays (a, b, p) and one s×17 result array.
- Each operand has its own write counter (0..s).
- LOAD state:
  - A word is accepted when load_valid_i is high and the selected operand's counter is below s. It is written at the counter index and the counter is incremented.
  - A write to an operand whose counter is already s is dropped and sets err_o.
  - go_i with all three counters equal to s: go to START.
  - go_i otherwise: ignored, err_o set.
- START state (one cycle):
  - start_o=1; a_base, b_ptr, p_ptr and res_wr_ptr cleared; go to RUN.
- RUN state:
  - a_o word k = a[a_base+k] when a_base+k < s, else 0. It is combinational from registered a_base.
  - a_shift_i: a_base += PE_NB. When a_base+PE_NB ≥ s, a_base wraps to 0.
  - b_o = b[b_ptr]. b_fetch_i at cycle t makes b_o show b[b_ptr+1] from t+1. The pointer wraps s-1 → 0.
  - p_ptr and p_o behave identically, driven by p_fetch_i.
  - res_push_i writes res_i to the result array at res_wr_ptr, then increments the pointer. A push when res_wr_ptr=s is dropped and sets err_o.
  - done_i: go to DRAIN; rd_ptr=0. If res_wr_ptr≠s at that point, set err_o.
  - res_push_i and done_i in the same cycle: the push is stored first, and the check uses the updated count.
- DRAIN state:
  - res_valid_o=1 and res_data_o=res[rd_ptr]. The result array is read combinationally from registered rd_ptr.
  - A beat transfers when res_valid_o and res_ready_i are both high; rd_ptr then increments.
  - After the transfer with rd_ptr=s-1: go to LOAD, clear the operand counters, res_valid_o=0.
- Strobe handling by state:
  - Strobes outside RUN (a_shift_i, fetches, res_push_i, done_i) are ignored and set err_o.
  - Exception: done_i during DRAIN is ignored without error.
  - go_i outside LOAD is ignored without error.
- Reset mid-RUN or mid-DRAIN: the next cycle is LOAD with all counters cleared. Any partial result is discarded.
- err_o stays set until reset.

Optional Feature:
- Macro: FIOS_OPSRV_CYCLE_COUNT_EN.
- When defined:
  - Adds output cycles_o [31:0]. It is cleared in START and increments every cycle in RUN, saturating at 0xFFFFFFFF.
  - cycles_o holds its value through DRAIN and LOAD until the next START.
  - Reset value is 0.
- When not defined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Basic run (s=8, PE_NB=8): load a=1..8, b=0x10..0x17, p=0x1FFFF×8, then go_i.
  - start_o high exactly 1 cycle.
  - a_o words 0..7 = 1..8.
  - b_o=0x10; after 9 b_fetch_i pulses, b_o=0x11 (wrap checked).
- Folded window (s=8, PE_NB=3), a=1..8:
  - Initial a_o = {3,2,1}.
  - After one shift {6,5,4}; after two {0,8,7}; after three {3,2,1}.
- Result collection: 8 res_push_i with values 0x100..0x107, then done_i.
  - Output 0x100..0x107 in order.
  - With res_ready_i toggling every cycle, no beat is lost or duplicated.
  - err_o=0; back in LOAD afterwards.
- Errors:
  - go_i with p only 7 words loaded → stays in LOAD, err_o=1.
  - 9th res_push_i → dropped, err_o=1.
  - done_i after 7 pushes → err_o=1.
- Reset: pull reset_n_i low during RUN after 3 pushes.
  - Next cycle: LOAD, load_ready_o=1, res_valid_o=0, err_o=0.
  - A full reload and go_i runs correctly.
- Cycle count (FIOS_OPSRV_CYCLE_COUNT_EN defined): done_i issued 50 cycles after start_o → cycles_o=50 throughout DRAIN.
